// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
// Main controller for the multi-cycle RV32I datapath. The datapath has one shared
// memory, an instruction register with oldPC, and an ALU-out register. This Moore FSM
// sequences fetch, decode, execute, memory and writeback. Memory accesses wait on a
// ready handshake and are guarded by a watchdog. Illegal opcodes, illegal branch
// funct3 values and memory timeouts halt the controller in TRAP until reset. Each
// completed instruction increments the retired counter.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   op_i, funct3_i      IR[6:0], IR[14:12]
//   zero_i, neg_i       ALU flags (neg is the less-than result for the branch compare)
//   mem_ready_i         memory completes the current request this cycle
//   mem_req_o/mem_we_o  memory request and its write qualifier
//   adr_src_o           address select: 0=PC, 1=ALU-out register
//   ir_write_o          load IR and oldPC
//   pc_write_o          load PC from the result mux
//   reg_write_o         register-file write enable
//   result_src_o        00=ALU-out reg, 01=mem data, 10=ALU direct, 11=imm
//   alu_src_a_o         00=PC, 01=oldPC, 10=rs1
//   alu_src_b_o         00=rs2, 01=imm, 10=const 4
//   alu_op_o            00=add, 01=sub/compare, 10=funct-decoded
//   imm_src_o           000=I, 001=S, 010=B, 011=U, 100=J
//   trap_o, trap_cause_o  halted flag and latched cause (01 opcode, 10 branch, 11 timeout)
//   retired_o           retired-instruction count, wraps
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE    | dispatch on opcode, branch target oldPC+immB into ALU-out
// EX_R      | rs1 op rs2
// EX_I      | rs1 op immI
// EX_ADDR   | effective address rs1+imm (I for load, S for store)
// EX_BR     | compare rs1/rs2, PC <= ALU-out when taken
// EX_JAL    | link value oldPC+4 into ALU-out
// EX_JALR   | link value oldPC+4 into ALU-out
// EX_LUI    | rd <= immU
// EX_AUIPC  | oldPC+immU
// JUMP      | rd <= link, ALU computes target
// JUMP_PC   | PC <= target
// MEM_RD    | load data read
// MEM_WR    | store data write
// WB_ALU    | rd <= ALU-out
// WB_MEM    | rd <= memory data
// TRAP      | halted until reset

module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32,
    parameter int TO_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             zero_i,
    input  logic             neg_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [2:0]       imm_src_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] CAUSE_OP = 2'b01;
    localparam logic [1:0] CAUSE_BR = 2'b10;
    localparam logic [1:0] CAUSE_TO = 2'b11;

    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(MEM_TIMEOUT);

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_EX_R,
        S_EX_I,
        S_EX_ADDR,
        S_EX_BR,
        S_EX_JAL,
        S_EX_JALR,
        S_EX_LUI,
        S_EX_AUIPC,
        S_JUMP,
        S_JUMP_PC,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [TO_W:0]    wait_inc;
    logic [1:0]       trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             is_jal;
    logic             br_cond;
    logic             br_taken;
    logic             br_illegal;
    logic             timeout;

    // Branch decode: funct3[2] picks the less-than flag over zero, funct3[0] inverts
    // the sense. funct3[2:1]=01 has no branch encoding.
    assign br_cond    = funct3_i[2] ? neg_i : zero_i;
    assign br_taken   = br_cond ^ funct3_i[0];
    assign br_illegal = (funct3_i[2:1] == 2'b01);

    // The IR is stable for the whole instruction, so JUMP/JUMP_PC can re-read the opcode
    // instead of keeping a separate JAL/JALR flag.
    assign is_jal = (op_i == OP_JAL);

    assign wait_inc = {1'b0, wait_q} + (TO_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        retire       = 1'b0;
        timeout      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        imm_src_o    = 3'b000;
        trap_o       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                result_src_o = 2'b10;
                alu_src_b_o  = 2'b10;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = 3'b010;
                case (op_i)
                    OP_R:               state_d = S_EX_R;
                    OP_I:               state_d = S_EX_I;
                    OP_LOAD, OP_STORE:  state_d = S_EX_ADDR;
                    OP_BR:              state_d = S_EX_BR;
                    OP_JAL:             state_d = S_EX_JAL;
                    OP_JALR:            state_d = S_EX_JALR;
                    OP_LUI:             state_d = S_EX_LUI;
                    OP_AUIPC:           state_d = S_EX_AUIPC;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = CAUSE_OP;
                    end
                endcase
            end
            S_EX_R: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b10;
                state_d     = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 2'b10;
                state_d     = S_WB_ALU;
            end
            S_EX_ADDR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                if (op_i == OP_STORE) begin
                    imm_src_o = 3'b001;
                    state_d   = S_MEM_WR;
                end else begin
                    state_d   = S_MEM_RD;
                end
            end
            S_EX_BR: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                if (br_illegal) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_BR;
                end else begin
                    pc_write_o = br_taken;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EX_JAL, S_EX_JALR: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                state_d     = S_JUMP;
            end
            S_JUMP, S_JUMP_PC: begin
                alu_src_a_o = is_jal ? 2'b01 : 2'b10;
                alu_src_b_o = 2'b01;
                imm_src_o   = is_jal ? 3'b100 : 3'b000;
                if (state_q == S_JUMP) begin
                    reg_write_o = 1'b1;
                    state_d     = S_JUMP_PC;
                end else begin
                    pc_write_o   = 1'b1;
                    result_src_o = 2'b10;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_EX_LUI: begin
                reg_write_o  = 1'b1;
                result_src_o = 2'b11;
                imm_src_o    = 3'b011;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_EX_AUIPC: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = 3'b011;
                state_d     = S_WB_ALU;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                result_src_o = 2'b01;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Watchdog: a late mem_ready on the limit cycle still completes normally,
        // since the check only fires while mem_ready is low.
        if ((MEM_TIMEOUT != 0) && mem_req_o && !mem_ready_i && (wait_inc == TO_LIM)) begin
            timeout = 1'b1;
        end
        if (timeout) begin
            state_d      = S_TRAP;
            trap_cause_d = CAUSE_TO;
        end

        // Counting only while the state is held means any entry into a request state
        // starts from zero.
        if (mem_req_o && !mem_ready_i && (state_d == state_q)) begin
            wait_d = wait_inc[TO_W-1:0];
        end else begin
            wait_d = '0;
        end

        retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            trap_cause_q <= 2'b00;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            trap_cause_q <= trap_cause_d;
            retired_q    <= retired_d;
        end
    end

    assign trap_cause_o = trap_cause_q;
    assign retired_o    = retired_q;

endmodule
